period_counter: RTL and testbench

Measures the period of an external square-wave input in whole milliseconds and presents the result as a 14-bit binary value (0–9999) for the binary-to-BCD converter and seven-segment display path. A measurement is armed by a one-cycle `start` request. The block times the interval between two consecutive rising edges of `si` with a millisecond prescaler, then pulses `done_tick`. The result register holds the last measurement so the display stays stable between runs.

---
 rtl/period_counter.sv | 128 ++++++++++++
 tb/tb_period_counter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_counter.sv
// Measures the spacing between two consecutive rising edges of si in whole
// milliseconds, saturating at 9999 ms with an overflow flag.
module period_counter #(
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        si,
    output logic        ready,
    output logic        done_tick,
    output logic [13:0] period,
    output logic        overflow
);

    // state      | meaning
    // S_IDLE     | waiting for start, ready high
    // S_WAIT     | armed, waiting for the first si rising edge
    // S_COUNT    | timing until the second edge or the 10000 ms limit
    // S_DONE     | result registered, done_tick high for one cycle
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int TICKS = CLK_FREQ_HZ / 1000;
    localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS - 1);
    localparam logic [13:0]   MS_LIMIT  = 14'd10000;
    localparam logic [13:0]   MS_SATVAL = 14'd9999;

    logic          meta_q, sync_q, sync_dly_q, edge_q;
    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d, tick_n;
    logic [13:0]   ms_q, ms_d, ms_n;
    logic [13:0]   period_q, period_d;
    logic          overflow_q, overflow_d;

    // Synchronizer plus registered edge detect: 3 clocks from si to edge_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            meta_q     <= si;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
            edge_q     <= sync_q & ~sync_dly_q;
        end
    end

    // tick_n/ms_n include the current cycle, so at the second edge ms_n is
    // floor(D / TICKS) where D is the clock spacing between detected edges.
    always_comb begin
        tick_n = tick_q;
        ms_n   = ms_q;
        if (tick_q == TICK_MAX) begin
            tick_n = '0;
            ms_n   = ms_q + 14'd1;
        end else begin
            tick_n = tick_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        ms_d       = ms_q;
        period_d   = period_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (edge_q) begin
                    tick_d  = '0;
                    ms_d    = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                tick_d = tick_n;
                ms_d   = ms_n;
                // The limit wins over a coincident edge.
                if (ms_n == MS_LIMIT) begin
                    period_d   = MS_SATVAL;
                    overflow_d = 1'b1;
                    state_d    = S_DONE;
                end else if (edge_q) begin
                    period_d   = ms_n;
                    overflow_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            ms_q       <= '0;
            period_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            ms_q       <= ms_d;
            period_q   <= period_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign period    = period_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_period_counter.sv
// Scoreboarded bench for period_counter: main instance at TICKS = 10, a second
// instance at TICKS = 2 keeps the saturation run short.
module tb_period_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, si = 1'b0;
    logic        ready, done_tick, overflow;
    logic [13:0] period;
    logic        start_s = 1'b0, si_s = 1'b0;
    logic        ready_s, done_s, overflow_s;
    logic [13:0] period_s;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int done_cnt_s = 0;
    logic [14:0] exp_q[$];

    period_counter #(.CLK_FREQ_HZ(10_000)) dut (
        .clk(clk), .reset(reset), .start(start), .si(si),
        .ready(ready), .done_tick(done_tick), .period(period), .overflow(overflow)
    );

    period_counter #(.CLK_FREQ_HZ(2_000)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .si(si_s),
        .ready(ready_s), .done_tick(done_s), .period(period_s), .overflow(overflow_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_tick) done_cnt <= done_cnt + 1;
        if (done_s) done_cnt_s <= done_cnt_s + 1;
    end

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done_tick) begin
                lat = i;
                break;
            end
        end
    endtask

    // Arms, then produces two si rising edges d clocks apart (d >= 2).
    task automatic measure(input int d, input logic [14:0] exp_v, input string name);
        int h;
        int lat;
        logic [14:0] e;
        pulse_start();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL %s armed_ready got=%b want=0", name, ready);
        end
        h = d / 2;
        si = 1'b1;
        repeat (h) @(negedge clk);
        si = 1'b0;
        repeat (d - h) @(negedge clk);
        si = 1'b1;
        exp_q.push_back(exp_v);
        wait_done(20, lat);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL %s done_latency got=%0d want=4", name, lat);
        end
        if (lat > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({overflow, period} !== e) begin
                bad++;
                $display("FAIL %s result got=%b/%0d want=%b/%0d", name,
                         overflow, period, e[14], e[13:0]);
            end
        end else begin
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        total++;
        if ({done_tick, ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s after_done got done=%b ready=%b want done=0 ready=1",
                     name, done_tick, ready);
        end
        si = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({ready, done_tick, overflow, period} !== {1'b1, 1'b0, 1'b0, 14'd0}) begin
            bad++;
            $display("FAIL reset_state got ready=%b done=%b ovf=%b period=%0d want 1/0/0/0",
                     ready, done_tick, overflow, period);
        end
        for (int i = 0; i < 5; i++) begin
            si = 1'b1;
            repeat (3) @(negedge clk);
            si = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        total++;
        if (done_cnt !== 0 || ready !== 1'b1 || period !== 14'd0) begin
            bad++;
            $display("FAIL idle_si_toggle got dones=%0d ready=%b period=%0d want 0/1/0",
                     done_cnt, ready, period);
        end
    endtask

    task automatic test_normal;
        measure(25, {1'b0, 14'd2}, "meas25");
        measure(30, {1'b0, 14'd3}, "meas30");
        measure(9,  {1'b0, 14'd0}, "meas9");
        measure(10, {1'b0, 14'd1}, "meas10_exact");
    endtask

    task automatic test_busy_start;
        int lat;
        int dc0;
        logic [14:0] e;
        dc0 = done_cnt;
        pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        si = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        si = 1'b0;
        repeat (15) @(negedge clk);
        si = 1'b1;
        exp_q.push_back({1'b0, 14'd3});
        wait_done(20, lat);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        total++;
        if (lat < 0) begin
            bad++;
            $display("FAIL busy_done got=timeout want=done_tick");
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if ({overflow, period} !== e) begin
                bad++;
                $display("FAIL busy_result got=%b/%0d want=%b/%0d",
                         overflow, period, e[14], e[13:0]);
            end
        end
        si = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if (ready !== 1'b1 || done_cnt - dc0 !== 1) begin
            bad++;
            $display("FAIL busy_ignored got ready=%b dones=%0d want ready=1 dones=1",
                     ready, done_cnt - dc0);
        end
    endtask

    // First detected edge is visible 3 negedges after si rises; the limit is
    // reached 20000 clocks later (TICKS=2) and done_tick follows one cycle on.
    task automatic test_saturation;
        int lat;
        logic [14:0] e;
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        si_s = 1'b1;
        exp_q.push_back({1'b1, 14'd9999});
        lat = -1;
        for (int i = 1; i <= 21000; i++) begin
            @(negedge clk);
            if (i == 5) si_s = 1'b0;
            if (done_s) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat !== 20004) begin
            bad++;
            $display("FAIL sat_latency got=%0d want=20004", lat);
        end
        e = exp_q.pop_front();
        total++;
        if ({overflow_s, period_s} !== e) begin
            bad++;
            $display("FAIL sat_result got=%b/%0d want=%b/%0d",
                     overflow_s, period_s, e[14], e[13:0]);
        end
        repeat (5) @(negedge clk);
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        si_s = 1'b1;
        repeat (20) @(negedge clk);
        si_s = 1'b0;
        repeat (20) @(negedge clk);
        si_s = 1'b1;
        exp_q.push_back({1'b0, 14'd20});
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_s) begin
                lat = i;
                break;
            end
        end
        e = exp_q.pop_front();
        total++;
        if (lat !== 4 || {overflow_s, period_s} !== e) begin
            bad++;
            $display("FAIL sat_followup got lat=%0d %b/%0d want lat=4 %b/%0d",
                     lat, overflow_s, period_s, e[14], e[13:0]);
        end
        si_s = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dc0;
        pulse_start();
        si = 1'b1;
        repeat (5) @(negedge clk);
        si = 1'b0;
        repeat (45) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({ready, done_tick, overflow, period} !== {1'b1, 1'b0, 1'b0, 14'd0}) begin
            bad++;
            $display("FAIL reset_mid got ready=%b done=%b ovf=%b period=%0d want 1/0/0/0",
                     ready, done_tick, overflow, period);
        end
        @(negedge clk) reset = 1'b0;
        dc0 = done_cnt;
        repeat (30) @(negedge clk);
        total++;
        if (done_cnt !== dc0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_quiet got dones=%0d ready=%b want 0/1",
                     done_cnt - dc0, ready);
        end
        measure(70, {1'b0, 14'd7}, "meas70");
    endtask

    task automatic test_held_result;
        int dc0;
        measure(50, {1'b0, 14'd5}, "meas50");
        dc0 = done_cnt;
        pulse_start();
        repeat (300) @(negedge clk);
        total++;
        if ({ready, overflow, period} !== {1'b0, 1'b0, 14'd5} || done_cnt !== dc0) begin
            bad++;
            $display("FAIL held got ready=%b ovf=%b period=%0d dones=%0d want 0/0/5/0",
                     ready, overflow, period, done_cnt - dc0);
        end
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_busy_start();
        test_saturation();
        test_reset_mid();
        test_held_result();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
